chirp_frame_sequencer: RTL and testbench
========================================

Name: chirp_frame_sequencer

Overview:
- Sequences one complete chirp frame: preamble upchirps, two sync upchirps, two downchirps, then N payload upchirps.
- Drives the run/enable input of the sample tick generator and consumes its active-low sample tick pulses.
- Publishes per-sample chirp direction, frequency offset and sample index to the chirp NCO/datapath.
- Pulls payload symbols through a valid/ready handshake.

Parameters:
- SF_BITWIDTH, 3, width of spreading-factor config (0..5 map to SF7..SF12).
- IDX_BITWIDTH, 12, width of sample index and chirp offset (covers 2^12 samples).
- NSYM_BITWIDTH, 8, width of payload symbol count.
- PREAMBLE_LEN, 8, number of preamble upchirps (1..15).
- SYNC_OFF0, 8, frequency offset of first sync chirp.
- SYNC_OFF1, 16, frequency offset of second sync chirp.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start_n  in  1  active-low level start request.
- i_sf_config  in  SF_BITWIDTH  spreading factor; latched at start.
- i_num_symbols  in  NSYM_BITWIDTH  payload symbol count; latched at start.
- i_sample_tick_n  in  1  active-low 1-cycle sample tick from tick generator.
- i_sym_data  in  IDX_BITWIDTH  payload symbol value.
- i_sym_valid  in  1  payload symbol valid.
- o_sym_ready  out  1  payload symbol accepted when high with i_sym_valid.
- o_tick_run_n  out  1  active-low run request to tick generator.
- o_chirp_dir  out  1  0 = upchirp, 1 = downchirp.
- o_chirp_offset  out  IDX_BITWIDTH  start-frequency offset of current chirp.
- o_sample_idx  out  IDX_BITWIDTH  sample index within current chirp.
- o_busy  out  1  high from start acceptance until DONE.
- o_done_n  out  1  active-low 1-cycle frame-complete pulse.

Behaviour:
- Reset (async, i_rst_n low): state IDLE; o_tick_run_n=1, o_chirp_dir=0, o_chirp_offset=0, o_sample_idx=0, o_sym_ready=0, o_busy=0, o_done_n=1. Latched config and counters are 0. Reset mid-frame aborts immediately; no done pulse.
- N = 2^(7+sf). sf values 6 and 7 are treated as sf=0 (SF7, N=128).
- States: IDLE, PREAMBLE, SYNC, DOWN, [QDOWN], WAIT_SYM, PAYLOAD, DONE.
- IDLE:
  - i_start_n sampled low: latch sf and num_symbols, o_busy=1, go to PREAMBLE with chirp counter 0.
- Chirp states (PREAMBLE/SYNC/DOWN/QDOWN/PAYLOAD):
  - o_tick_run_n=0.
  - Each cycle with i_sample_tick_n low increments o_sample_idx.
  - The tick where o_sample_idx == N-1 ends the chirp: o_sample_idx wraps to 0 and the chirp counter increments.
  - Ticks in any other state are ignored.
- PREAMBLE: dir=0, offset=0; PREAMBLE_LEN chirps, then SYNC.
- SYNC: dir=0; offset SYNC_OFF0 then SYNC_OFF1; 2 chirps, then DOWN.
- DOWN: dir=1, offset=0; 2 chirps, then QDOWN if enabled.
  - Otherwise go to WAIT_SYM, or to DONE if num_symbols==0.
- WAIT_SYM:
  - o_tick_run_n=1 and o_sym_ready=1 (registered, asserted on state entry).
  - On i_sym_valid & o_sym_ready: latch o_chirp_offset=i_sym_data, set dir=0, go to PAYLOAD.
  - Missing data stalls indefinitely; no ticks are consumed.
- PAYLOAD: one chirp. At its end, decrement the remaining count; go to WAIT_SYM if nonzero, else DONE.
- DONE:
  - o_done_n=0 for exactly one cycle; o_busy=0, o_tick_run_n=1.
  - Return to IDLE only after i_start_n is seen high, so a held-low start never retriggers.
  - o_done_n returns to 1 the cycle after DONE entry.
- A tick coinciding with a state transition belongs to the outgoing chirp.
- Config inputs are ignored while o_busy=1.

Optional Feature:
- Macro: CHIRP_QUARTER_DOWN_EN.
- Defined: QDOWN state after DOWN, dir=1, offset=0. It lasts N/4 samples (ends when o_sample_idx == N/4-1), then WAIT_SYM or DONE.
- Undefined: QDOWN is absent; DOWN goes directly to WAIT_SYM or DONE.

Decomposition:
- Package chirp_pkg holds:
  - state encoding constants;
  - SF-to-N function;
  - SF7 base constant;
  - dir encoding (UP=0, DOWN=1).
- One natural sub-module, chirp_sample_counter: the IDX_BITWIDTH sample counter with end-of-chirp compare against a programmable limit (N-1 or N/4-1). It takes the tick input and a clear, and outputs idx and last.

Test Plan:
- SF7 (sf=0), num_symbols=2, symbols 5 and 100 presented immediately, feature off -> exactly 1792 ticks consumed in run-active states. Offsets sequence 0×8, 8, 16, 0, 0, 5, 100; dir=1 only in DOWN; one o_done_n pulse.
- Same as above with CHIRP_QUARTER_DOWN_EN defined -> 1824 ticks; QDOWN ends at o_sample_idx=31.
- num_symbols=0 -> DONE directly after 12th chirp; o_sym_ready never asserted.
- Withhold i_sym_valid for 500 cycles in WAIT_SYM -> o_tick_run_n=1 and o_sample_idx=0 held. Valid asserted -> PAYLOAD next cycle with latched offset.
- Assert i_rst_n low mid-SYNC -> all outputs at reset values immediately (asynchronous); no o_done_n pulse.
- Hold i_start_n low through DONE -> single frame only, then IDLE after i_start_n goes high. sf=7 -> N=128.

Source files
------------

// File: rtl/chirp_pkg.sv
// rtl/chirp_pkg.sv - state encoding, chirp direction codes and SF-to-N helper shared by the chirp frame sequencer
package chirp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_DOWN,
    ST_QDOWN,
    ST_WAIT_SYM,
    ST_PAYLOAD,
    ST_DONE
  } state_t;

  localparam int   SF7_BASE    = 7;
  localparam int   SF_MAX_CODE = 5;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  // Codes beyond SF12 fold back to SF7.
  function automatic int unsigned sf_to_n(input int unsigned sf);
    int unsigned s;
    s = (sf > SF_MAX_CODE) ? 32'd0 : sf;
    return 32'd1 << (SF7_BASE + s);
  endfunction

endpackage

// File: rtl/chirp_sample_counter.sv
// rtl/chirp_sample_counter.sv - per-chirp sample index with end-of-chirp detect against a programmable limit
module chirp_sample_counter #(
  parameter int IDX_BITWIDTH = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_tick,
  input  logic [IDX_BITWIDTH-1:0] i_limit,
  output logic [IDX_BITWIDTH-1:0] o_idx,
  output logic                    o_last
);

  assign o_last = i_tick && (o_idx == i_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_idx <= '0;
    end else if (i_clear) begin
      o_idx <= '0;
    end else if (i_tick) begin
      o_idx <= o_last ? '0 : o_idx + IDX_BITWIDTH'(1);
    end
  end

endmodule

// File: rtl/chirp_frame_sequencer.sv
// rtl/chirp_frame_sequencer.sv - sequences preamble, sync, down and payload chirps of one frame
// Optional quarter downchirp after the two downchirps: define CHIRP_QUARTER_DOWN_EN.
module chirp_frame_sequencer
  import chirp_pkg::*;
#(
  parameter int SF_BITWIDTH   = 3,
  parameter int IDX_BITWIDTH  = 12,
  parameter int NSYM_BITWIDTH = 8,
  parameter int PREAMBLE_LEN  = 8,
  parameter int SYNC_OFF0     = 8,
  parameter int SYNC_OFF1     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start_n,
  input  logic [SF_BITWIDTH-1:0]   i_sf_config,
  input  logic [NSYM_BITWIDTH-1:0] i_num_symbols,
  input  logic                     i_sample_tick_n,
  input  logic [IDX_BITWIDTH-1:0]  i_sym_data,
  input  logic                     i_sym_valid,
  output logic                     o_sym_ready,
  output logic                     o_tick_run_n,
  output logic                     o_chirp_dir,
  output logic [IDX_BITWIDTH-1:0]  o_chirp_offset,
  output logic [IDX_BITWIDTH-1:0]  o_sample_idx,
  output logic                     o_busy,
  output logic                     o_done_n
);

  state_t                    state;
  logic [SF_BITWIDTH-1:0]    sf_q;
  logic [NSYM_BITWIDTH-1:0]  sym_left;
  logic [3:0]                chirp_cnt;
  logic                      chirp_state;
  logic                      tick;
  logic                      last;
  logic [IDX_BITWIDTH-1:0]   limit;
  int unsigned               n_samples;

  // Ticks only count while a chirp is being played out.
  assign chirp_state = state inside {ST_PREAMBLE, ST_SYNC, ST_DOWN, ST_QDOWN, ST_PAYLOAD};
  assign tick        = chirp_state && !i_sample_tick_n;
  assign n_samples   = sf_to_n(32'(sf_q));

  always_comb begin
    limit = IDX_BITWIDTH'(n_samples - 32'd1);
`ifdef CHIRP_QUARTER_DOWN_EN
    if (state == ST_QDOWN) limit = IDX_BITWIDTH'((n_samples >> 2) - 32'd1);
`endif
  end

  chirp_sample_counter #(.IDX_BITWIDTH(IDX_BITWIDTH)) u_sample_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (state == ST_IDLE),
    .i_tick  (tick),
    .i_limit (limit),
    .o_idx   (o_sample_idx),
    .o_last  (last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      sf_q           <= '0;
      sym_left       <= '0;
      chirp_cnt      <= '0;
      o_sym_ready    <= 1'b0;
      o_tick_run_n   <= 1'b1;
      o_chirp_dir    <= DIR_UP;
      o_chirp_offset <= '0;
      o_busy         <= 1'b0;
      o_done_n       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (!i_start_n) begin
          state          <= ST_PREAMBLE;
          sf_q           <= i_sf_config;
          sym_left       <= i_num_symbols;
          chirp_cnt      <= '0;
          o_busy         <= 1'b1;
          o_tick_run_n   <= 1'b0;
          o_chirp_dir    <= DIR_UP;
          o_chirp_offset <= '0;
        end
        ST_PREAMBLE: if (last) begin
          chirp_cnt <= chirp_cnt + 4'd1;
          if (chirp_cnt == 4'(PREAMBLE_LEN - 1)) begin
            state          <= ST_SYNC;
            chirp_cnt      <= '0;
            o_chirp_offset <= IDX_BITWIDTH'(SYNC_OFF0);
          end
        end
        ST_SYNC: if (last) begin
          if (chirp_cnt == 4'd0) begin
            chirp_cnt      <= 4'd1;
            o_chirp_offset <= IDX_BITWIDTH'(SYNC_OFF1);
          end else begin
            state          <= ST_DOWN;
            chirp_cnt      <= '0;
            o_chirp_dir    <= DIR_DOWN;
            o_chirp_offset <= '0;
          end
        end
        ST_DOWN: if (last) begin
          chirp_cnt <= chirp_cnt + 4'd1;
          if (chirp_cnt == 4'd1) begin
            chirp_cnt <= '0;
`ifdef CHIRP_QUARTER_DOWN_EN
            state     <= ST_QDOWN;
          end
        end
        ST_QDOWN: if (last) begin
          begin
`endif
            o_tick_run_n <= 1'b1;
            o_chirp_dir  <= DIR_UP;
            if (sym_left == '0) begin
              state    <= ST_DONE;
              o_busy   <= 1'b0;
              o_done_n <= 1'b0;
            end else begin
              state       <= ST_WAIT_SYM;
              o_sym_ready <= 1'b1;
            end
          end
        end
        ST_WAIT_SYM: if (i_sym_valid && o_sym_ready) begin
          state          <= ST_PAYLOAD;
          o_sym_ready    <= 1'b0;
          o_tick_run_n   <= 1'b0;
          o_chirp_dir    <= DIR_UP;
          o_chirp_offset <= i_sym_data;
        end
        ST_PAYLOAD: if (last) begin
          sym_left     <= sym_left - NSYM_BITWIDTH'(1);
          o_tick_run_n <= 1'b1;
          if (sym_left == NSYM_BITWIDTH'(1)) begin
            state    <= ST_DONE;
            o_busy   <= 1'b0;
            o_done_n <= 1'b0;
          end else begin
            state       <= ST_WAIT_SYM;
            o_sym_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          o_done_n <= 1'b1;
          // A start held low across the frame must not launch a second one.
          if (i_start_n) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_frame_sequencer.sv
// tb/tb_chirp_frame_sequencer.sv - self-checking bench for chirp_frame_sequencer (honours CHIRP_QUARTER_DOWN_EN)
`timescale 1ns/1ps
module tb_chirp_frame_sequencer;

  localparam int IDX_W  = 12;
  localparam int NSYM_W = 8;
  localparam int PRE    = 8;
  localparam int OFF0   = 8;
  localparam int OFF1   = 16;
`ifdef CHIRP_QUARTER_DOWN_EN
  localparam bit QD_EN = 1'b1;
`else
  localparam bit QD_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start_n;
  logic [2:0]        i_sf_config;
  logic [NSYM_W-1:0] i_num_symbols;
  logic              i_sample_tick_n;
  logic [IDX_W-1:0]  i_sym_data;
  logic              i_sym_valid;
  logic              o_sym_ready;
  logic              o_tick_run_n;
  logic              o_chirp_dir;
  logic [IDX_W-1:0]  o_chirp_offset;
  logic [IDX_W-1:0]  o_sample_idx;
  logic              o_busy;
  logic              o_done_n;

  chirp_frame_sequencer dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start_n       (i_start_n),
    .i_sf_config     (i_sf_config),
    .i_num_symbols   (i_num_symbols),
    .i_sample_tick_n (i_sample_tick_n),
    .i_sym_data      (i_sym_data),
    .i_sym_valid     (i_sym_valid),
    .o_sym_ready     (o_sym_ready),
    .o_tick_run_n    (o_tick_run_n),
    .o_chirp_dir     (o_chirp_dir),
    .o_chirp_offset  (o_chirp_offset),
    .o_sample_idx    (o_sample_idx),
    .o_busy          (o_busy),
    .o_done_n        (o_done_n)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic dir; logic [IDX_W-1:0] off; logic [IDX_W-1:0] idx; } tick_t;
  typedef struct { int sf; int nsym; int gap; int hold; int base_ticks; int qd_ticks; int s0; int s1; } vec_t;

  tick_t            exp_q[$];
  tick_t            mm_act, mm_exp;
  logic [IDX_W-1:0] sym_arr[4];
  int pos, mism, mm_pos, done_cnt, ready_seen;
  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: a list of chirps expanded to one record per expected tick.
  task automatic push_chirp(input logic dir, input int off, input int len);
    tick_t t;
    for (int i = 0; i < len; i++) begin
      t.dir = dir; t.off = IDX_W'(off); t.idx = IDX_W'(i);
      exp_q.push_back(t);
    end
  endtask

  task automatic build_model(input int sf, input int nsym);
    int n;
    n = 1 << (7 + ((sf > 5) ? 0 : sf));
    exp_q.delete();
    for (int c = 0; c < PRE; c++) push_chirp(1'b0, 0, n);
    push_chirp(1'b0, OFF0, n);
    push_chirp(1'b0, OFF1, n);
    push_chirp(1'b1, 0, n);
    push_chirp(1'b1, 0, n);
    if (QD_EN) push_chirp(1'b1, 0, n / 4);
    for (int k = 0; k < nsym; k++) push_chirp(1'b0, int'(sym_arr[k]), n);
  endtask

  initial begin
    i_sample_tick_n = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      i_sample_tick_n = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (!o_tick_run_n && !i_sample_tick_n) begin
          if (pos < exp_q.size()) begin
            if (o_chirp_dir !== exp_q[pos].dir || o_chirp_offset !== exp_q[pos].off ||
                o_sample_idx !== exp_q[pos].idx) begin
              if (mism == 0) begin
                mm_pos = pos; mm_exp = exp_q[pos];
                mm_act.dir = o_chirp_dir; mm_act.off = o_chirp_offset; mm_act.idx = o_sample_idx;
              end
              mism++;
            end
          end
          pos++;
        end
        if (!o_done_n) done_cnt++;
        if (o_sym_ready) ready_seen = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic feed_syms(input int nsym, input int gap);
    for (int k = 0; k < nsym; k++) begin
      int w = 0;
      int bad = 0;
      do begin @(negedge i_clk); w++; end while (!o_sym_ready && w < 20000);
      check("sym_ready_seen", int'(o_sym_ready), 1);
      if (!o_sym_ready) return;
      repeat (gap) begin
        @(negedge i_clk);
        if (!o_tick_run_n || o_sample_idx != '0 || !o_sym_ready) bad++;
      end
      if (gap > 0) check("stall_hold", bad, 0);
      @(posedge i_clk); #1;
      i_sym_valid = 1'b1; i_sym_data = sym_arr[k];
      @(posedge i_clk); #1;
      i_sym_valid = 1'b0; i_sym_data = IDX_W'($urandom);
      @(negedge i_clk);
      check("payload_run_n", int'(o_tick_run_n), 0);
      check("payload_offset", int'(o_chirp_offset), int'(sym_arr[k]));
      check("payload_idx", int'(o_sample_idx), 0);
    end
  endtask

  task automatic run_frame(input int sf, input int nsym, input int gap, input int hold, input int exp_ticks);
    int bad = 0;
    build_model(sf, nsym);
    pos = 0; mism = 0; done_cnt = 0; ready_seen = 0;
    @(posedge i_clk); #1;
    i_sf_config = 3'(sf); i_num_symbols = NSYM_W'(nsym); i_start_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("busy_on_start", int'(o_busy), 1);
    @(posedge i_clk); #1;
    i_sf_config = 3'($urandom); i_num_symbols = NSYM_W'($urandom);
    fork
      feed_syms(nsym, gap);
      begin
        int got = 0;
        for (int c = 0; c < 60000; c++) begin
          @(negedge i_clk);
          if (!o_done_n) begin got = 1; break; end
        end
        check("done_seen", got, 1);
      end
    join
    repeat (hold) begin
      @(negedge i_clk);
      if (o_busy || !o_tick_run_n) bad++;
    end
    check("no_retrigger", bad, 0);
    check("done_pulses", done_cnt, 1);
    check($sformatf("tick_stream first@%0d dir/off/idx %0d/%0d/%0d want %0d/%0d/%0d", mm_pos,
                    mm_act.dir, mm_act.off, mm_act.idx, mm_exp.dir, mm_exp.off, mm_exp.idx), mism, 0);
    check("tick_count_model", pos, exp_q.size());
    if (exp_ticks >= 0) check("tick_count_table", pos, exp_ticks);
    if (nsym == 0) check("ready_never", ready_seen, 0);
    @(posedge i_clk); #1;
    i_start_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("idle_busy", int'(o_busy), 0);
    check("idle_run_n", int'(o_tick_run_n), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run_n"}, int'(o_tick_run_n), 1);
    check({tag, "_dir"}, int'(o_chirp_dir), 0);
    check({tag, "_offset"}, int'(o_chirp_offset), 0);
    check({tag, "_idx"}, int'(o_sample_idx), 0);
    check({tag, "_ready"}, int'(o_sym_ready), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done_n"}, int'(o_done_n), 1);
  endtask

  vec_t vecs[5];

  initial begin
    int w;
    vecs[0] = '{0, 2, 0,   5, 1792, 32, 5, 100};
    vecs[1] = '{0, 0, 0,   5, 1536, 32, 0, 0};
    vecs[2] = '{0, 1, 500, 3, 1664, 32, 777, 0};
    vecs[3] = '{7, 1, 2,  40, 1664, 32, 4095, 0};
    vecs[4] = '{1, 1, 0,   3, 3328, 64, 200, 0};

    i_rst_n = 1'b0; i_start_n = 1'b1; i_sf_config = '0; i_num_symbols = '0;
    i_sym_data = '0; i_sym_valid = 1'b0;
    pos = 0; mism = 0; done_cnt = 0; ready_seen = 0; mm_pos = 0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    #2 i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check_reset_outputs("idle");

    for (int v = 0; v < 5; v++) begin
      sym_arr[0] = IDX_W'(vecs[v].s0);
      sym_arr[1] = IDX_W'(vecs[v].s1);
      run_frame(vecs[v].sf, vecs[v].nsym, vecs[v].gap, vecs[v].hold,
                vecs[v].base_ticks + (QD_EN ? vecs[v].qd_ticks : 0));
    end

    // Asynchronous abort in the middle of the first sync chirp.
    build_model(0, 1);
    pos = 0; mism = 0; done_cnt = 0;
    @(posedge i_clk); #1;
    i_sf_config = 3'd0; i_num_symbols = NSYM_W'(1); i_start_n = 1'b0;
    @(posedge i_clk); #1;
    i_start_n = 1'b1;
    w = 0;
    do begin @(negedge i_clk); w++; end while (o_chirp_offset != IDX_W'(OFF0) && w < 20000);
    check("reached_sync", int'(o_chirp_offset), OFF0);
    repeat (20) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    check("abort_prefix_stream", mism, 0);
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", int'(o_busy), 0);

    for (int r = 0; r < 3; r++) begin
      int sfp, ns;
      sfp = $urandom_range(0, 3);
      ns  = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) sym_arr[k] = IDX_W'($urandom_range(0, 4095));
      run_frame((sfp == 0) ? 0 : (sfp == 1) ? 6 : (sfp == 2) ? 7 : 1, ns,
                $urandom_range(0, 10), $urandom_range(1, 5), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
